// File: rtl/key_pkg.sv
// Shared constants for the key click decoder: state encoding and default sizes.
// CNT_WIN_SIM is the short window used by simulation builds.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        WAIT2 = 2'd2
    } key_state_e;

    localparam int          CNT_W_DEF       = 24;
    localparam logic [23:0] CNT_WIN_MAX_DEF = 24'd14_999_999;
    localparam int          EVT_CNT_W_DEF   = 8;
    localparam logic [23:0] CNT_WIN_SIM     = 24'd19;

endpackage

// File: rtl/key_click_decoder.sv
// Classifies debounced key presses into single/double click pulses.
// Define KEY_TRIPLE_CLICK_EN to add a WAIT2 state and a triple_click output.
module key_click_decoder
    import key_pkg::*;
#(
    parameter int                CNT_W       = CNT_W_DEF,
    parameter logic [CNT_W-1:0]  CNT_WIN_MAX = CNT_WIN_MAX_DEF,
    parameter int                EVT_CNT_W   = EVT_CNT_W_DEF
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 key_flag,
    output logic                 single_click,
    output logic                 double_click,
`ifdef KEY_TRIPLE_CLICK_EN
    output logic                 triple_click,
`endif
    output logic                 busy,
    output logic [EVT_CNT_W-1:0] evt_cnt
);

    localparam logic [CNT_W-1:0]     TIMER_ONE = 1;
    localparam logic [EVT_CNT_W-1:0] EVT_ONE   = 1;

    key_state_e       state;
    key_state_e       state_nxt;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] timer_nxt;
    logic             at_max;
    logic             single_nxt;
    logic             double_nxt;
    logic             evt_inc;
`ifdef KEY_TRIPLE_CLICK_EN
    logic             triple_nxt;
`endif

    assign at_max = (timer == CNT_WIN_MAX);

    // A press always beats the timeout when both land on the last window cycle.
    always_comb begin
        state_nxt  = state;
        timer_nxt  = '0;
        single_nxt = 1'b0;
        double_nxt = 1'b0;
`ifdef KEY_TRIPLE_CLICK_EN
        triple_nxt = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (key_flag) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (key_flag) begin
`ifdef KEY_TRIPLE_CLICK_EN
                    state_nxt  = WAIT2;
`else
                    state_nxt  = IDLE;
                    double_nxt = 1'b1;
`endif
                end else if (at_max) begin
                    state_nxt  = IDLE;
                    single_nxt = 1'b1;
                end else begin
                    timer_nxt  = timer + TIMER_ONE;
                end
            end
`ifdef KEY_TRIPLE_CLICK_EN
            WAIT2: begin
                if (key_flag) begin
                    state_nxt  = IDLE;
                    triple_nxt = 1'b1;
                end else if (at_max) begin
                    state_nxt  = IDLE;
                    double_nxt = 1'b1;
                end else begin
                    timer_nxt  = timer + TIMER_ONE;
                end
            end
`endif
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef KEY_TRIPLE_CLICK_EN
    assign evt_inc = single_nxt | double_nxt | triple_nxt;
`else
    assign evt_inc = single_nxt | double_nxt;
`endif

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state        <= IDLE;
            timer        <= '0;
            single_click <= 1'b0;
            double_click <= 1'b0;
`ifdef KEY_TRIPLE_CLICK_EN
            triple_click <= 1'b0;
`endif
            busy         <= 1'b0;
            evt_cnt      <= '0;
        end else begin
            state        <= state_nxt;
            timer        <= timer_nxt;
            single_click <= single_nxt;
            double_click <= double_nxt;
`ifdef KEY_TRIPLE_CLICK_EN
            triple_click <= triple_nxt;
`endif
            busy         <= (state_nxt != IDLE);
            if (evt_inc) begin
                evt_cnt <= evt_cnt + EVT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_key_click_decoder.sv
// Directed bench for key_click_decoder with a 20-cycle click window.
// Cycle numbers in test names refer to the first press landing in cycle 10.
module tb_key_click_decoder;
    import key_pkg::*;

    logic       sys_clk;
    logic       sys_rst;
    logic       key_flag;
    logic       single_click;
    logic       double_click;
`ifdef KEY_TRIPLE_CLICK_EN
    logic       triple_click;
`endif
    logic       busy;
    logic [7:0] evt_cnt;

    logic [7:0] exp_evt;
    int         n_pass;
    int         n_total;

    key_click_decoder #(
        .CNT_W       (24),
        .CNT_WIN_MAX (CNT_WIN_SIM),
        .EVT_CNT_W   (8)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .key_flag     (key_flag),
        .single_click (single_click),
        .double_click (double_click),
`ifdef KEY_TRIPLE_CLICK_EN
        .triple_click (triple_click),
`endif
        .busy         (busy),
        .evt_cnt      (evt_cnt)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        sys_rst  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            key_flag = i[0] ? 1'b0 : 1'b1;
            tick();
            n_total++;
            if ({single_click, double_click, busy} !== 3'b000 || evt_cnt !== 8'd0)
                $display("FAIL reset_state cyc%0d got s=%b d=%b b=%b e=%0d exp all 0",
                         i, single_click, double_click, busy, evt_cnt);
            else n_pass++;
        end
        key_flag = 1'b0;
        sys_rst  = 1'b0;
        exp_evt  = 8'd0;
        tick();
    endtask

    task automatic test_single();
        int bad_c;
        bad_c = 0;
        key_flag = 1'b1;
        tick();
        key_flag = 1'b0;
        for (int c = 11; c <= 30; c++) begin
            if (bad_c == 0 && (busy !== 1'b1 || single_click !== 1'b0 || double_click !== 1'b0))
                bad_c = c;
            if (c < 30) tick();
        end
        n_total++;
        if (bad_c != 0)
            $display("FAIL single_window cyc%0d got b=%b s=%b d=%b exp b=1 s=0 d=0",
                     bad_c, busy, single_click, double_click);
        else n_pass++;
        tick();
        exp_evt++;
        n_total++;
        if (single_click !== 1'b1 || double_click !== 1'b0 || busy !== 1'b0)
            $display("FAIL single_pulse got s=%b d=%b b=%b exp s=1 d=0 b=0",
                     single_click, double_click, busy);
        else n_pass++;
        n_total++;
        if (evt_cnt !== exp_evt)
            $display("FAIL single_evt got %0d exp %0d", evt_cnt, exp_evt);
        else n_pass++;
        tick();
        n_total++;
        if (single_click !== 1'b0)
            $display("FAIL single_width got s=%b exp 0", single_click);
        else n_pass++;
    endtask

`ifndef KEY_TRIPLE_CLICK_EN
    task automatic test_double();
        int bad_c;
        key_flag = 1'b1;
        tick();
        key_flag = 1'b0;
        idle(4);
        key_flag = 1'b1;
        tick();
        key_flag = 1'b0;
        exp_evt++;
        n_total++;
        if (double_click !== 1'b1 || single_click !== 1'b0 || busy !== 1'b0)
            $display("FAIL double_pulse got d=%b s=%b b=%b exp d=1 s=0 b=0",
                     double_click, single_click, busy);
        else n_pass++;
        n_total++;
        if (evt_cnt !== exp_evt)
            $display("FAIL double_evt got %0d exp %0d", evt_cnt, exp_evt);
        else n_pass++;
        bad_c = 0;
        for (int c = 17; c <= 41; c++) begin
            tick();
            if (bad_c == 0 && (single_click | double_click | busy) !== 1'b0) bad_c = c;
        end
        n_total++;
        if (bad_c != 0)
            $display("FAIL double_quiet cyc%0d got s=%b d=%b b=%b exp 0",
                     bad_c, single_click, double_click, busy);
        else n_pass++;
    endtask
`endif

    task automatic test_boundary();
`ifndef KEY_TRIPLE_CLICK_EN
        key_flag = 1'b1;
        tick();
        key_flag = 1'b0;
        idle(19);
        key_flag = 1'b1;
        tick();
        key_flag = 1'b0;
        exp_evt++;
        n_total++;
        if (double_click !== 1'b1 || single_click !== 1'b0)
            $display("FAIL bound_t19 got d=%b s=%b exp d=1 s=0", double_click, single_click);
        else n_pass++;
        tick();
        n_total++;
        if (single_click !== 1'b0 || evt_cnt !== exp_evt)
            $display("FAIL bound_t19_after got s=%b e=%0d exp s=0 e=%0d",
                     single_click, evt_cnt, exp_evt);
        else n_pass++;
        idle(2);
`endif
        key_flag = 1'b1;
        tick();
        key_flag = 1'b0;
        idle(20);
        exp_evt++;
        n_total++;
        if (single_click !== 1'b1 || double_click !== 1'b0 || evt_cnt !== exp_evt)
            $display("FAIL bound_t20 got s=%b d=%b e=%0d exp s=1 d=0 e=%0d",
                     single_click, double_click, evt_cnt, exp_evt);
        else n_pass++;
        key_flag = 1'b1;
        tick();
        key_flag = 1'b0;
        n_total++;
        if (busy !== 1'b1 || single_click !== 1'b0)
            $display("FAIL bound_reopen got b=%b s=%b exp b=1 s=0", busy, single_click);
        else n_pass++;
        idle(20);
        exp_evt++;
        n_total++;
        if (single_click !== 1'b1 || evt_cnt !== exp_evt)
            $display("FAIL bound_reopen_single got s=%b e=%0d exp s=1 e=%0d",
                     single_click, evt_cnt, exp_evt);
        else n_pass++;
        tick();
    endtask

    task automatic test_mid_reset();
        int bad_c;
        key_flag = 1'b1;
        tick();
        key_flag = 1'b0;
        idle(7);
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        exp_evt = 8'd0;
        n_total++;
        if (busy !== 1'b0 || evt_cnt !== 8'd0 || single_click !== 1'b0 || double_click !== 1'b0)
            $display("FAIL midrst_state got b=%b e=%0d s=%b d=%b exp 0",
                     busy, evt_cnt, single_click, double_click);
        else n_pass++;
        bad_c = 0;
        for (int c = 0; c < 25; c++) begin
            tick();
            if (bad_c == 0 && (single_click | double_click | busy) !== 1'b0) bad_c = c + 1;
        end
        n_total++;
        if (bad_c != 0)
            $display("FAIL midrst_quiet cyc+%0d got s=%b d=%b b=%b exp 0",
                     bad_c, single_click, double_click, busy);
        else n_pass++;
    endtask

    task automatic test_wrap();
        for (int n = 1; n <= 256; n++) begin
            key_flag = 1'b1;
            tick();
            key_flag = 1'b0;
            idle(21);
            exp_evt++;
            if (n == 255) begin
                n_total++;
                if (evt_cnt !== 8'd255)
                    $display("FAIL wrap_255 got %0d exp 255", evt_cnt);
                else n_pass++;
            end
        end
        n_total++;
        if (evt_cnt !== 8'd0 || exp_evt !== 8'd0)
            $display("FAIL wrap_0 got %0d exp 0", evt_cnt);
        else n_pass++;
    endtask

`ifdef KEY_TRIPLE_CLICK_EN
    task automatic test_triple();
        key_flag = 1'b1;
        tick();
        key_flag = 1'b0;
        idle(4);
        key_flag = 1'b1;
        tick();
        key_flag = 1'b0;
        n_total++;
        if (busy !== 1'b1 || double_click !== 1'b0)
            $display("FAIL triple_wait2 got b=%b d=%b exp b=1 d=0", busy, double_click);
        else n_pass++;
        idle(4);
        key_flag = 1'b1;
        tick();
        key_flag = 1'b0;
        exp_evt++;
        n_total++;
        if (triple_click !== 1'b1 || double_click !== 1'b0 || evt_cnt !== exp_evt)
            $display("FAIL triple_pulse got t=%b d=%b e=%0d exp t=1 d=0 e=%0d",
                     triple_click, double_click, evt_cnt, exp_evt);
        else n_pass++;
        tick();
        key_flag = 1'b1;
        tick();
        key_flag = 1'b0;
        idle(4);
        key_flag = 1'b1;
        tick();
        key_flag = 1'b0;
        idle(20);
        exp_evt++;
        n_total++;
        if (double_click !== 1'b1 || triple_click !== 1'b0 || single_click !== 1'b0 ||
            evt_cnt !== exp_evt)
            $display("FAIL wait2_timeout got d=%b t=%b s=%b e=%0d exp d=1 t=0 s=0 e=%0d",
                     double_click, triple_click, single_click, evt_cnt, exp_evt);
        else n_pass++;
        tick();
    endtask
`endif

    initial begin
        n_pass   = 0;
        n_total  = 0;
        exp_evt  = 8'd0;
        sys_rst  = 1'b1;
        key_flag = 1'b0;
        test_reset();
        test_single();
`ifndef KEY_TRIPLE_CLICK_EN
        test_double();
`endif
        test_boundary();
        test_mid_reset();
`ifdef KEY_TRIPLE_CLICK_EN
        test_triple();
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        exp_evt = 8'd0;
`endif
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/key_click_decoder.md
Name: key_click_decoder

Overview:
- Sits directly downstream of key_filter.
- Consumes key_filter's single-cycle debounced press pulse (key_flag).
- Classifies presses into single-click and double-click events using a programmable inter-press window, and keeps a wrap-around count of decoded events.
- Outputs drive LED/mode-select logic in the same design.

Parameters:
- CNT_W, 24, width of the window timer.
- CNT_WIN_MAX, 24'd14_999_999, last timer value inside the double-click window (300 ms at 50 MHz); simulation uses 24'd19.
- EVT_CNT_W, 8, width of evt_cnt.

Ports:
- sys_clk  in  1  system clock; all logic on rising edge.
- sys_rst  in  1  reset, synchronous, active-high.
- key_flag  in  1  single-cycle debounced press pulse from key_filter.
- single_click  out  1  one-cycle pulse: exactly one press in the window.
- double_click  out  1  one-cycle pulse: second press arrived inside the window.
- busy  out  1  high while a window is open (state != IDLE).
- evt_cnt  out  EVT_CNT_W  count of decoded events (single + double); wraps.

Behaviour:
- Reset:
  - sys_rst high at a rising edge forces: state=IDLE, timer=0, single_click=0, double_click=0, busy=0, evt_cnt=0.
  - Reset wins over every other event, including mid-window; no pulse is emitted for an aborted window.
- States: IDLE, WAIT.
- IDLE:
  - key_flag=1 -> WAIT, timer<=0.
  - Otherwise stay; timer holds 0.
- WAIT, timer increments by 1 each cycle:
  - key_flag=1 at any timer value 0..CNT_WIN_MAX -> double_click<=1 next cycle, state<=IDLE, timer<=0.
  - key_flag=0 and timer==CNT_WIN_MAX -> single_click<=1 next cycle, state<=IDLE, timer<=0.
  - Simultaneous key_flag=1 and timer==CNT_WIN_MAX -> double wins; single_click is not asserted.
- Latency: outputs are registered.
  - double_click is high in the cycle after the second key_flag.
  - single_click is high in the cycle after timer reaches CNT_WIN_MAX, i.e. CNT_WIN_MAX+2 cycles after the first key_flag.
- Pulses are exactly one cycle wide; single_click and double_click are never high together.
- key_flag in the cycle that returns to IDLE (same edge as the decision) is ignored. A third press after a double opens a new window only if it arrives after that cycle.
- busy = (state==WAIT), registered with the state.
- evt_cnt:
  - Increments by 1 in the same cycle either pulse is driven high.
  - Wraps from 2^EVT_CNT_W-1 to 0; no saturation.
- Input contract: key_flag is single-cycle. Multi-cycle highs are treated as consecutive presses; no internal edge detection.
- Timer never exceeds CNT_WIN_MAX; no overflow path exists.

Optional Feature:
- Macro: KEY_TRIPLE_CLICK_EN.
- Defined:
  - Adds output port triple_click (1 bit) and state WAIT2.
  - A second press in WAIT goes to WAIT2 with timer<=0 instead of pulsing.
  - In WAIT2, a third press inside the window -> triple_click pulse, IDLE.
  - WAIT2 timeout -> double_click pulse, IDLE.
  - Same simultaneity rule applies: the press wins over the timeout.
  - evt_cnt counts triple events as well.
- Undefined: no triple_click port, no WAIT2; behaviour exactly as above.

Decomposition:
- Shared package key_pkg holds:
  - state encoding localparams (IDLE=2'd0, WAIT=2'd1, WAIT2=2'd2);
  - default CNT_W / CNT_WIN_MAX / EVT_CNT_W;
  - simulation window constant CNT_WIN_SIM=24'd19.
- No sub-module; timer and FSM are tightly coupled and stay in one module (~150 lines).

Test Plan (CNT_WIN_MAX=19):
- Reset: hold sys_rst high 3 cycles with key_flag pulsing -> all outputs 0, evt_cnt=0, busy=0.
- Single press at cycle 10, no further press -> busy high cycles 11..30; single_click high only at cycle 31; evt_cnt=1.
- Presses at cycles 10 and 15 -> double_click high at cycle 16; no single_click; evt_cnt=1; busy low from cycle 16.
- Boundary: second press exactly when timer==19 -> double_click, no single_click. Second press when timer would be 20 (after the return to IDLE) -> single_click, then a new window opens.
- Reset asserted mid-window (timer=7) -> no pulse, state IDLE, evt_cnt=0.
- Wrap: 256 single events -> evt_cnt returns to 0.
- With KEY_TRIPLE_CLICK_EN: presses at cycles 10, 15, 20 -> triple_click at cycle 21, evt_cnt=1.
